// File: rtl/uart_sram_loader_pkg.sv
// ---------------------------------------------------------------------------
// uart_sram_loader_pkg
//
// Shared definitions for the UART-to-SRAM image loader:
//   ULD_state_type       - loader FSM state encoding (S_ULD_* states)
//   UART_SRAM_BASE       - default SRAM address of the first loaded word
//   UART_SRAM_NUM_WORDS  - default number of 16-bit words per load
//                          (one 320x240 image)
// ---------------------------------------------------------------------------
package uart_sram_loader_pkg;

  // Loader FSM states, in the order a single word walks through them.
  typedef enum logic [2:0] {
    S_ULD_IDLE      = 3'd0,
    S_ULD_WAIT_HI   = 3'd1,
    S_ULD_UNLOAD_HI = 3'd2,
    S_ULD_WAIT_LO   = 3'd3,
    S_ULD_UNLOAD_LO = 3'd4,
    S_ULD_WRITE     = 3'd5,
    S_ULD_DONE      = 3'd6
  } ULD_state_type;

  localparam logic [17:0] UART_SRAM_BASE      = 18'd0;
  localparam logic [17:0] UART_SRAM_NUM_WORDS = 18'd76800;

endpackage

// File: rtl/uart_sram_loader.sv
// ---------------------------------------------------------------------------
// uart_sram_loader
//
// Drains bytes from the UART receive controller through its Empty /
// Unload_data handshake, packs byte pairs into 16-bit words (high byte
// first) and writes them to consecutive SRAM addresses starting at
// BASE_ADDR until NUM_WORDS words have been written.
//
// Ports:
//   Clock_50         in   system clock (50 MHz)
//   Reset            in   asynchronous, active-high reset
//   Start            in   one-cycle pulse, begins a load from IDLE or DONE
//   RX_data[7:0]     in   received byte from the UART receiver
//   RX_empty         in   receiver Empty flag (0 = byte available)
//   RX_overrun       in   receiver Overrun flag
//   RX_frame_error   in   receiver Frame_error flag
//   RX_enable        out  Enable to the UART receiver
//   RX_unload        out  Unload_data pulse to the UART receiver
//   SRAM_address     out  SRAM write address
//   SRAM_write_data  out  SRAM write data
//   SRAM_we_n        out  active-low SRAM write enable
//   Busy             out  high from accepted Start until the last write
//   Done             out  high after the final write until the next Start
//   Error            out  sticky overrun / frame error flag for this load
//
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module uart_sram_loader
  import uart_sram_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = UART_SRAM_BASE,
  parameter logic [ADDR_WIDTH-1:0] NUM_WORDS  = UART_SRAM_NUM_WORDS
) (
  input  logic                  Clock_50,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [7:0]            RX_data,
  input  logic                  RX_empty,
  input  logic                  RX_overrun,
  input  logic                  RX_frame_error,
  output logic                  RX_enable,
  output logic                  RX_unload,
  output logic [ADDR_WIDTH-1:0] SRAM_address,
  output logic [15:0]           SRAM_write_data,
  output logic                  SRAM_we_n,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  // Index of the final word of a load; the counter runs 0 .. LAST_WORD.
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD =
    NUM_WORDS - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  ULD_state_type         state_q, state_d;
  logic                  rxEnable_q, rxEnable_d;
  logic                  rxUnload_q, rxUnload_d;
  logic [ADDR_WIDTH-1:0] sramAddress_q, sramAddress_d;
  logic [15:0]           sramWriteData_q, sramWriteData_d;
  logic                  sramWeN_q, sramWeN_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] wordCount_q, wordCount_d;
  logic [7:0]            highByte_q, highByte_d;
  logic                  frameErrPrev_q, frameErrPrev_d;

  logic                  lastWord;
  logic                  errorEvent;

  assign lastWord = (wordCount_q == LAST_WORD);

  // Only a new frame error counts, so a receiver that holds its flag high
  // is reported once; overrun is level-sensitive. Both are only of interest
  // while a load is in progress.
  assign errorEvent = busy_q &&
                      (RX_overrun || (RX_frame_error && !frameErrPrev_q));

  // State and output registers. Reset puts the loader back to idle at once,
  // abandoning any half-built word; SRAM contents already written stay.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q         <= S_ULD_IDLE;
      rxEnable_q      <= 1'b0;
      rxUnload_q      <= 1'b0;
      sramAddress_q   <= BASE_ADDR;
      sramWriteData_q <= 16'h0000;
      sramWeN_q       <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      wordCount_q     <= '0;
      highByte_q      <= 8'h00;
      frameErrPrev_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      rxEnable_q      <= rxEnable_d;
      rxUnload_q      <= rxUnload_d;
      sramAddress_q   <= sramAddress_d;
      sramWriteData_q <= sramWriteData_d;
      sramWeN_q       <= sramWeN_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      wordCount_q     <= wordCount_d;
      highByte_q      <= highByte_d;
      frameErrPrev_q  <= frameErrPrev_d;
    end
  end

  // Next-state logic. Each word takes five states: wait/unload for the high
  // byte, wait/unload for the low byte, then the write cycle. The unload
  // states never look at RX_empty because the receiver only clears its
  // Empty flag one cycle after seeing Unload_data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ULD_IDLE,
      S_ULD_DONE: begin
        if (Start) begin
          state_d = S_ULD_WAIT_HI;
        end
      end
      S_ULD_WAIT_HI: begin
        if (!RX_empty) begin
          state_d = S_ULD_UNLOAD_HI;
        end
      end
      S_ULD_UNLOAD_HI: begin
        state_d = S_ULD_WAIT_LO;
      end
      S_ULD_WAIT_LO: begin
        if (!RX_empty) begin
          state_d = S_ULD_UNLOAD_LO;
        end
      end
      S_ULD_UNLOAD_LO: begin
        state_d = S_ULD_WRITE;
      end
      S_ULD_WRITE: begin
        state_d = lastWord ? S_ULD_DONE : S_ULD_WAIT_HI;
      end
      default: begin
        state_d = S_ULD_IDLE;
      end
    endcase
  end

  // Output and datapath next values. Registers hold by default; RX_unload
  // and SRAM_we_n fall back to their inactive levels every cycle so each
  // becomes a single-cycle pulse. Data is placed on SRAM_write_data one
  // cycle before the write strobe and the address only advances after the
  // strobe, so both are stable for the whole low phase of SRAM_we_n.
  always_comb begin
    rxEnable_d      = rxEnable_q;
    rxUnload_d      = 1'b0;
    sramAddress_d   = sramAddress_q;
    sramWriteData_d = sramWriteData_q;
    sramWeN_d       = 1'b1;
    busy_d          = busy_q;
    done_d          = done_q;
    error_d         = error_q;
    wordCount_d     = wordCount_q;
    highByte_d      = highByte_q;
    frameErrPrev_d  = RX_frame_error;

    if (errorEvent) begin
      error_d = 1'b1;
    end

    case (state_q)
      S_ULD_IDLE,
      S_ULD_DONE: begin
        if (Start) begin
          error_d       = 1'b0;
          done_d        = 1'b0;
          sramAddress_d = BASE_ADDR;
          wordCount_d   = '0;
          rxEnable_d    = 1'b1;
          busy_d        = 1'b1;
        end
      end
      S_ULD_WAIT_HI: begin
        if (!RX_empty) begin
          highByte_d = RX_data;
          rxUnload_d = 1'b1;
        end
      end
      S_ULD_WAIT_LO: begin
        if (!RX_empty) begin
          sramWriteData_d = {highByte_q, RX_data};
          rxUnload_d      = 1'b1;
        end
      end
      S_ULD_UNLOAD_LO: begin
        sramWeN_d = 1'b0;
      end
      S_ULD_WRITE: begin
        if (lastWord) begin
          rxEnable_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          wordCount_d   = wordCount_q + 1'b1;
          sramAddress_d = sramAddress_q + 1'b1;
        end
      end
      S_ULD_UNLOAD_HI: begin
      end
      default: begin
        rxEnable_d      = 1'b0;
        sramAddress_d   = BASE_ADDR;
        sramWriteData_d = 16'h0000;
        busy_d          = 1'b0;
        done_d          = 1'b0;
        error_d         = 1'b0;
        wordCount_d     = '0;
        highByte_d      = 8'h00;
      end
    endcase
  end

  assign RX_enable       = rxEnable_q;
  assign RX_unload       = rxUnload_q;
  assign SRAM_address    = sramAddress_q;
  assign SRAM_write_data = sramWriteData_q;
  assign SRAM_we_n       = sramWeN_q;
  assign Busy            = busy_q;
  assign Done            = done_q;
  assign Error           = error_q;

endmodule
